// File: rtl/score_pkg.sv
// score_pkg: shared score width, default win threshold and score type
package score_pkg;
  localparam int SCORE_W = 7;
  localparam int WIN_SCORE_DEF = 50;
  typedef logic [SCORE_W-1:0] score_t;
endpackage

// File: rtl/score_tracker_if.sv
// score_tracker_if: collision inputs (goodColl, badColl) and score outputs (currScore, highScore, isGameComplete); master = collision side, slave = tracker
interface score_tracker_if import score_pkg::*; #(parameter int WIDTH = SCORE_W);
  logic goodColl;
  logic badColl;
  logic [WIDTH-1:0] currScore;
  logic [WIDTH-1:0] highScore;
  logic isGameComplete;
  modport master (output goodColl, badColl, input currScore, highScore, isGameComplete);
  modport slave (input goodColl, badColl, output currScore, highScore, isGameComplete);
endinterface

// File: rtl/score_tracker_coll_edge_det.sv
// coll_edge_det: rising-edge pulse from a level input; ports clk, nRst (async active-high), in -> pulse
module coll_edge_det (
  input  logic clk,
  input  logic nRst,
  input  logic in,
  output logic pulse
);
  logic r_prev;
  always_ff @(posedge clk or posedge nRst)
    if (nRst) r_prev <= 1'b0;
    else r_prev <= in;
  assign pulse = in & ~r_prev;
endmodule

// File: rtl/score_tracker.sv
// score_tracker: current/high score and sticky win flag; ports clk, nRst (async active-high), bus (score_tracker_if.slave); SCORE_EDGE_DETECT_EN edge-detects collision inputs
module score_tracker import score_pkg::*; #(
  parameter int WIDTH = SCORE_W,
  parameter int WIN_SCORE = WIN_SCORE_DEF
) (
  input logic clk,
  input logic nRst,
  score_tracker_if.slave bus
);
  logic w_good, w_bad;
`ifdef SCORE_EDGE_DETECT_EN
  coll_edge_det u_good (.clk(clk), .nRst(nRst), .in(bus.goodColl), .pulse(w_good));
  coll_edge_det u_bad (.clk(clk), .nRst(nRst), .in(bus.badColl), .pulse(w_bad));
`else
  assign w_good = bus.goodColl;
  assign w_bad = bus.badColl;
`endif
  logic [WIDTH-1:0] r_curr, r_high, w_curr_next, w_high_next;
  logic r_done, w_done_next;
  // badColl dominates; a won game freezes the score; all-ones saturates
  always_comb begin
    w_curr_next = w_bad ? '0 : (w_good && !r_done && !(&r_curr)) ? r_curr + 1'b1 : r_curr;
    w_done_next = !w_bad && (r_done || w_curr_next == WIDTH'(WIN_SCORE));
    w_high_next = w_curr_next > r_high ? w_curr_next : r_high;
  end
  always_ff @(posedge clk or posedge nRst)
    if (nRst) begin
      r_curr <= '0;
      r_high <= '0;
      r_done <= 1'b0;
    end else begin
      r_curr <= w_curr_next;
      r_high <= w_high_next;
      r_done <= w_done_next;
    end
  assign bus.currScore = r_curr;
  assign bus.highScore = r_high;
  assign bus.isGameComplete = r_done;
endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: randomized and directed checks of score_tracker against a behavioural score model
module tb_score_tracker;
  localparam int W = 7;
  localparam int WIN = 50;
  localparam int MAXS = (1 << W) - 1;
  logic clk = 1'b0;
  logic nRst = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_curr, m_high, m_done, m_pg, m_pb;
  score_tracker_if #(.WIDTH(W)) bus ();
  score_tracker #(.WIDTH(W), .WIN_SCORE(WIN)) dut (.clk(clk), .nRst(nRst), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_curr = 0; m_high = 0; m_done = 0; m_pg = 0; m_pb = 0;
  endfunction

  // one clock edge of the game rules, applied to whole-number scores
  function automatic void model_step(int g, int b);
    int eg, eb;
`ifdef SCORE_EDGE_DETECT_EN
    eg = g & ~m_pg; eb = b & ~m_pb;
`else
    eg = g; eb = b;
`endif
    m_pg = g; m_pb = b;
    if (eb != 0) begin
      m_curr = 0;
      m_done = 0;
    end else begin
      if (eg != 0 && m_done == 0 && m_curr < MAXS) m_curr++;
      if (m_curr == WIN) m_done = 1;
    end
    if (m_curr > m_high) m_high = m_curr;
  endfunction

  task automatic cyc(input int g, input int b);
    bus.goodColl = g[0];
    bus.badColl = b[0];
    @(posedge clk);
    model_step(g, b);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRst = 1'b1;
    model_reset();
    @(negedge clk);
    nRst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.goodColl = 1'b0;
    bus.badColl = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin cyc(1, 0); cyc(0, 0); end
    #2;
    nRst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.currScore !== 0 || bus.highScore !== 0 || bus.isGameComplete !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got curr=%0d high=%0d done=%0b want 0 0 0", bus.currScore, bus.highScore, bus.isGameComplete);
    end
    bus.goodColl = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.currScore !== 0 || bus.highScore !== 0 || bus.isGameComplete !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got curr=%0d high=%0d done=%0b want 0 0 0", bus.currScore, bus.highScore, bus.isGameComplete);
    end
    bus.goodColl = 1'b0;
    @(negedge clk);
    nRst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_count();
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0);
      checks++;
      if (bus.currScore !== W'(i) || bus.highScore !== W'(i) || m_curr != i) begin
        errors++;
        $display("FAIL count_%0d: got curr=%0d high=%0d want %0d %0d", i, bus.currScore, bus.highScore, i, i);
      end
      cyc(0, 0);
    end
  endtask

  task automatic test_bad();
    cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
    cyc(0, 1);
    checks++;
    if (bus.currScore !== 0 || bus.highScore !== W'(m_high) || bus.isGameComplete !== 1'b0) begin
      errors++;
      $display("FAIL bad_clear: got curr=%0d high=%0d want 0 %0d", bus.currScore, bus.highScore, m_high);
    end
    cyc(0, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 0);
      checks++;
      if (bus.currScore !== W'(m_curr) || bus.highScore !== W'(m_high)) begin
        errors++;
        $display("FAIL bad_recount_%0d: got curr=%0d high=%0d want %0d %0d", i, bus.currScore, bus.highScore, m_curr, m_high);
      end
      cyc(0, 0);
    end
  endtask

  task automatic test_both();
    do_reset();
    for (int i = 0; i < 5; i++) begin cyc(1, 0); cyc(0, 0); end
    cyc(1, 1);
    checks++;
    if (bus.currScore !== 0 || bus.highScore !== 5 || m_high != 5) begin
      errors++;
      $display("FAIL both_bad_wins: got curr=%0d high=%0d want 0 5", bus.currScore, bus.highScore);
    end
    cyc(0, 0);
  endtask

  task automatic test_win();
    do_reset();
    for (int i = 1; i <= WIN; i++) begin
      cyc(1, 0);
      checks++;
      if (bus.currScore !== W'(m_curr) || bus.isGameComplete !== (i == WIN)) begin
        errors++;
        $display("FAIL win_step_%0d: got curr=%0d done=%0b want %0d %0b", i, bus.currScore, bus.isGameComplete, i, i == WIN);
      end
      cyc(0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0);
      checks++;
      if (bus.currScore !== W'(WIN) || bus.isGameComplete !== 1'b1) begin
        errors++;
        $display("FAIL win_frozen: got curr=%0d done=%0b want %0d 1", bus.currScore, bus.isGameComplete, WIN);
      end
      cyc(0, 0);
    end
    cyc(0, 1);
    checks++;
    if (bus.currScore !== 0 || bus.highScore !== W'(WIN) || bus.isGameComplete !== 1'b0) begin
      errors++;
      $display("FAIL win_bad: got curr=%0d high=%0d done=%0b want 0 %0d 0", bus.currScore, bus.highScore, bus.isGameComplete, WIN);
    end
    cyc(0, 0);
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 3; i++) begin cyc(1, 0); cyc(0, 0); end
    #3;
    nRst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.currScore !== 0 || bus.highScore !== 0 || bus.isGameComplete !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got curr=%0d high=%0d done=%0b want 0 0 0", bus.currScore, bus.highScore, bus.isGameComplete);
    end
    @(negedge clk);
    nRst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 79) == 0) ? 1 : 0);
      checks++;
      if (bus.currScore !== W'(m_curr) || bus.highScore !== W'(m_high) || bus.isGameComplete !== (m_done != 0)) begin
        errors++;
        $display("FAIL random_%0d: got curr=%0d high=%0d done=%0b want %0d %0d %0d", i, bus.currScore, bus.highScore, bus.isGameComplete, m_curr, m_high, m_done);
      end
    end
  endtask

  initial begin
    bus.goodColl = 1'b0;
    bus.badColl = 1'b0;
    model_reset();
    test_reset();
    test_count();
    test_bad();
    test_both();
    test_win();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
